// File: rtl/regfile_seq_if.sv
// Handshake and datapath-control bundle between instruction source and regfile_seq.
// Pure wiring, no latency; start/done is the only handshake.
// The source holds start until it sees busy low.
interface regfile_seq_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          start;
    logic [15:0]   instr;
    logic          busy;
    logic          done;
    logic          illegal;
    logic [RW-1:0] readnum;
    logic [RW-1:0] writenum;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          loadc;
    logic          loads;
    logic          asel;
    logic          bsel;
    logic          vsel;
    logic [1:0]    shift;
    logic [1:0]    aluop;
    logic [DW-1:0] sximm8;

    modport master (
        output start, instr,
        input  busy, done, illegal, readnum, writenum, write,
        input  loada, loadb, loadc, loads, asel, bsel, vsel, shift, aluop, sximm8
    );

    modport slave (
        input  start, instr,
        output busy, done, illegal, readnum, writenum, write,
        output loada, loadb, loadc, loads, asel, bsel, vsel, shift, aluop, sximm8
    );
endinterface

// File: rtl/regfile_seq.sv
// Multicycle controller sequencing the register-file datapath, one instruction per start/done.
// Latency from accept edge to done: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6, illegal 2.
// start is sampled only in WAIT; requests while busy are ignored, not queued.
module regfile_seq #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    regfile_seq_if.slave  bus
);

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } instr_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI,
        K_MOVR,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN,
        K_ILL
    } kind_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    state_t state_q, state_d;
    instr_t ir_q;
    kind_t  kind;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && bus.start)
                ir_q <= instr_t'(bus.instr);
        end
    end

    always_comb begin
        kind = K_ILL;
        case (ir_q.opcode)
            3'b110: begin
                if (ir_q.op == 2'b10)      kind = K_MOVI;
                else if (ir_q.op == 2'b00) kind = K_MOVR;
                else                       kind = K_ILL;
            end
            3'b101: begin
                case (ir_q.op)
                    2'b00:   kind = K_ADD;
                    2'b01:   kind = K_CMP;
                    2'b10:   kind = K_AND;
                    default: kind = K_MVN;
                endcase
            end
            default: kind = K_ILL;
        endcase
    end

    logic          busy_c, done_c, illegal_c;
    logic [RW-1:0] readnum_c, writenum_c;
    logic          write_c, loada_c, loadb_c, loadc_c, loads_c;
    logic          asel_c, vsel_c;
    logic [1:0]    shift_c, aluop_c;

    always_comb begin
        state_d    = state_q;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        illegal_c  = 1'b0;
        readnum_c  = '0;
        writenum_c = '0;
        write_c    = 1'b0;
        loada_c    = 1'b0;
        loadb_c    = 1'b0;
        loadc_c    = 1'b0;
        loads_c    = 1'b0;
        asel_c     = 1'b0;
        vsel_c     = 1'b0;
        shift_c    = 2'b00;
        aluop_c    = 2'b00;

        case (state_q)
            S_WAIT: begin
                busy_c = 1'b0;
                if (bus.start) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    K_MOVI:               state_d = S_WR_REG;
                    K_MOVR, K_MVN:        state_d = S_GET_B;
                    K_ADD, K_CMP, K_AND:  state_d = S_GET_A;
                    default:              state_d = S_DONE;
                endcase
            end
            S_GET_A: begin
                readnum_c = RW'(ir_q.rn);
                loada_c   = 1'b1;
                state_d   = S_GET_B;
            end
            S_GET_B: begin
                readnum_c = RW'(ir_q.rm);
                loadb_c   = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                shift_c = ir_q.sh;
                // MOV reg and MVN have no A operand; zeroing A turns MOV into 0 + B.
                asel_c  = (kind == K_MOVR) || (kind == K_MVN);
                case (kind)
                    K_CMP:   aluop_c = ALU_SUB;
                    K_AND:   aluop_c = ALU_AND;
                    K_MVN:   aluop_c = ALU_NOTB;
                    default: aluop_c = ALU_ADD;
                endcase
                if (kind == K_CMP) begin
                    loads_c = 1'b1;
                    state_d = S_DONE;
                end else begin
                    loadc_c = 1'b1;
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: begin
                write_c = 1'b1;
                if (kind == K_MOVI) begin
                    writenum_c = RW'(ir_q.rn);
                    vsel_c     = 1'b1;
                end else begin
                    writenum_c = RW'(ir_q.rd);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_c    = 1'b1;
                illegal_c = (kind == K_ILL);
                state_d   = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.illegal  = illegal_c;
    assign bus.readnum  = readnum_c;
    assign bus.writenum = writenum_c;
    assign bus.write    = write_c;
    assign bus.loada    = loada_c;
    assign bus.loadb    = loadb_c;
    assign bus.loadc    = loadc_c;
    assign bus.loads    = loads_c;
    assign bus.asel     = asel_c;
    assign bus.bsel     = 1'b0;
    assign bus.vsel     = vsel_c;
    assign bus.shift    = shift_c;
    assign bus.aluop    = aluop_c;
    assign bus.sximm8   = {{(DW-8){ir_q[7]}}, ir_q[7:0]};

    a_done_returns_idle: assert property (@(posedge clk) disable iff (reset)
        done_c |=> !bus.busy);
    a_accept_goes_busy: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_WAIT && bus.start) |=> bus.busy);

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq: vector table of whole instructions plus hand sequences
// for held start, and reset during EXEC.
module tb_regfile_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_seq_if #(.DW(16), .RW(3)) bus ();

    regfile_seq #(.DW(16), .RW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [36:0] all_outs;
    assign all_outs = {bus.busy, bus.done, bus.illegal, bus.readnum, bus.writenum,
                       bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads,
                       bus.asel, bus.bsel, bus.vsel, bus.shift, bus.aluop, bus.sximm8};

    typedef struct {
        logic [15:0] ins;
        int lat;
        int nla, nlb, nlc, nls, nw;
        int ra, rb, wn, vs, alu, asl, sh, sx, ill;
    } vec_t;

    vec_t tbl [10];

    int o_lat, o_nla, o_nlb, o_nlc, o_nls, o_nw;
    int o_ra, o_rb, o_wn, o_vs, o_alu, o_asl, o_sh, o_sx, o_ill, o_bsel, o_busy_lo;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (bus.busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("idle before start", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_instr(input logic [15:0] ins);
        wait_idle();
        bus.start = 1'b1;
        bus.instr = ins;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.instr = ~ins;
        o_lat = 0; o_nla = 0; o_nlb = 0; o_nlc = 0; o_nls = 0; o_nw = 0;
        o_ra = 0; o_rb = 0; o_wn = 0; o_vs = 0; o_alu = 0; o_asl = 0; o_sh = 0;
        o_sx = 0; o_ill = 0; o_bsel = 0; o_busy_lo = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!bus.busy) o_busy_lo++;
            if (bus.bsel) o_bsel = 1;
            if (bus.loada) begin o_nla++; o_ra = int'(bus.readnum); end
            if (bus.loadb) begin o_nlb++; o_rb = int'(bus.readnum); end
            if (bus.loadc) o_nlc++;
            if (bus.loads) o_nls++;
            if (bus.loadc || bus.loads) begin
                o_alu = int'(bus.aluop);
                o_asl = int'(bus.asel);
                o_sh  = int'(bus.shift);
            end
            if (bus.write) begin
                o_nw++;
                o_wn = int'(bus.writenum);
                o_vs = int'(bus.vsel);
                o_sx = int'(bus.sximm8);
            end
            if (bus.done) begin
                o_ill = int'(bus.illegal);
                o_lat = c;
                break;
            end
        end
    endtask

    initial begin
        //           ins       lat nla nlb nlc nls nw ra rb wn vs alu asl sh sx       ill
        tbl[0] = '{16'hD3FE, 3, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 'hFFFE, 0}; // MOV R3,#-2
        tbl[1] = '{16'hA148, 6, 1, 1, 1, 0, 1, 1, 0, 2, 0, 0, 0, 1, 'h0048, 0}; // ADD R2,R1,R0 LSL
        tbl[2] = '{16'hA900, 5, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0,      0}; // CMP R1,R0
        tbl[3] = '{16'hB885, 5, 0, 1, 1, 0, 1, 0, 5, 4, 0, 3, 1, 0, 'hFF85, 0}; // MVN R4,R5
        tbl[4] = '{16'h0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1}; // illegal opcode 000
        tbl[5] = '{16'hC0FE, 5, 0, 1, 1, 0, 1, 0, 6, 7, 0, 0, 1, 3, 'hFFFE, 0}; // MOV R7,R6 sh=11
        tbl[6] = '{16'hB3B2, 6, 1, 1, 1, 0, 1, 3, 2, 5, 0, 2, 0, 2, 'hFFB2, 0}; // AND R5,R3,R2 sh=10
        tbl[7] = '{16'hC800, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1}; // illegal 110/01
        tbl[8] = '{16'hE000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1}; // illegal opcode 111
        tbl[9] = '{16'hD57F, 3, 0, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0, 0, 'h007F, 0}; // MOV R5,#127

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.instr = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset outputs zero", 64'(all_outs), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", 64'(all_outs), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].ins);
            chk($sformatf("v%0d latency", i), 64'(o_lat), 64'(tbl[i].lat));
            chk($sformatf("v%0d illegal", i), 64'(o_ill), 64'(tbl[i].ill));
            chk($sformatf("v%0d loada cnt", i), 64'(o_nla), 64'(tbl[i].nla));
            chk($sformatf("v%0d loadb cnt", i), 64'(o_nlb), 64'(tbl[i].nlb));
            chk($sformatf("v%0d loadc cnt", i), 64'(o_nlc), 64'(tbl[i].nlc));
            chk($sformatf("v%0d loads cnt", i), 64'(o_nls), 64'(tbl[i].nls));
            chk($sformatf("v%0d write cnt", i), 64'(o_nw), 64'(tbl[i].nw));
            chk($sformatf("v%0d busy low", i), 64'(o_busy_lo), 64'd0);
            chk($sformatf("v%0d bsel", i), 64'(o_bsel), 64'd0);
            if (tbl[i].nla > 0)
                chk($sformatf("v%0d readnum A", i), 64'(o_ra), 64'(tbl[i].ra));
            if (tbl[i].nlb > 0)
                chk($sformatf("v%0d readnum B", i), 64'(o_rb), 64'(tbl[i].rb));
            if (tbl[i].nlc + tbl[i].nls > 0) begin
                chk($sformatf("v%0d aluop", i), 64'(o_alu), 64'(tbl[i].alu));
                chk($sformatf("v%0d asel", i), 64'(o_asl), 64'(tbl[i].asl));
                chk($sformatf("v%0d shift", i), 64'(o_sh), 64'(tbl[i].sh));
            end
            if (tbl[i].nw > 0) begin
                chk($sformatf("v%0d writenum", i), 64'(o_wn), 64'(tbl[i].wn));
                chk($sformatf("v%0d vsel", i), 64'(o_vs), 64'(tbl[i].vs));
                chk($sformatf("v%0d sximm8", i), 64'(o_sx), 64'(tbl[i].sx));
            end
        end

        // start held high: illegal first, then a MOV imm presented after the accept edge
        wait_idle();
        bus.start = 1'b1;
        bus.instr = 16'h0000;
        @(posedge clk);
        #1 bus.instr = 16'hD3FE;
        @(negedge clk);
        chk("held c1 busy", 64'(bus.busy), 64'd1);
        chk("held c1 done", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("held c2 done+illegal", 64'({bus.done, bus.illegal, bus.write}), 64'b110);
        @(negedge clk);
        chk("held c3 busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("held c4 busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("held c5 write/wn", 64'({bus.write, bus.writenum}), 64'({1'b1, 3'd3}));
        @(negedge clk);
        chk("held c6 done/illegal", 64'({bus.done, bus.illegal}), 64'b10);
        bus.start = 1'b0;

        // reset while ADD R2,R1,R0 is in EXEC
        wait_idle();
        bus.start = 1'b1;
        bus.instr = 16'hA148;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset EXEC loadc", 64'(bus.loadc), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset all zero", 64'(all_outs), 64'd0);
        reset = 1'b0;
        begin
            int nw;
            nw = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.write) nw++;
            end
            chk("abandoned no write", 64'(nw), 64'd0);
        end
        run_instr(16'hD3FE);
        chk("post-reset MOV latency", 64'(o_lat), 64'd3);
        chk("post-reset MOV writenum", 64'(o_wn), 64'd3);
        chk("post-reset MOV write cnt", 64'(o_nw), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
